// File: rtl/lcd_bus_writer_pkg.sv
// Shared definitions for the LCD bus writer: FSM encoding, FIFO entry layout,
// counter sizing and byte-mode half-select values.
package lcd_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WR_LO = 2'd2,
        ST_WR_HI = 2'd3
    } state_t;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic ID_INS  = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam int BYTE_W = 8;
    localparam logic HALF_HI = 1'b0;
    localparam logic HALF_LO = 1'b1;

    // The ID flag sits directly above the payload in a FIFO entry.
    function automatic int id_bit(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/lcd_bus_writer_if.sv
// FIFO read port plus 8080-style LCD write bus. Define LCD_BYTE_MODE_EN to
// narrow LCD_DATA to 8 bits.
interface lcd_bus_writer_if #(
    parameter int DW = 16
);
    import lcd_bus_pkg::*;

`ifdef LCD_BYTE_MODE_EN
    localparam int LW = BYTE_W;
`else
    localparam int LW = DW;
`endif

    logic          fifo_rempty;
    logic [DW:0]   fifo_rdata;
    logic          fifo_rinc;
    logic          LCD_CS;
    logic          LCD_RS;
    logic          LCD_WR;
    logic          LCD_RD;
    logic [LW-1:0] LCD_DATA;
    logic          busy;

    modport master (
        input  fifo_rempty, fifo_rdata,
        output fifo_rinc, LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_DATA, busy
    );

    modport slave (
        output fifo_rempty, fifo_rdata,
        input  fifo_rinc, LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_DATA, busy
    );

endinterface

// File: rtl/lcd_bus_writer.sv
// Pops {ID, payload} entries from the printer output FIFO and strobes them onto
// the LCD write bus. LCD_BYTE_MODE_EN selects two 8-bit strobes per entry.
module lcd_bus_writer
    import lcd_bus_pkg::*;
#(
    parameter int DW          = 16,
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    lcd_bus_writer_if.master bus
);

`ifdef LCD_BYTE_MODE_EN
    localparam int LW = BYTE_W;
`else
    localparam int LW = DW;
`endif

    localparam int ID_BIT = id_bit(DW);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(WR_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(WR_HIGH_CYC - 1);

    if (WR_LOW_CYC < 1 || WR_LOW_CYC > CNT_MAX) begin : g_bad_low
        $error("lcd_bus_writer: WR_LOW_CYC must be within 1..15");
    end
    if (WR_HIGH_CYC < 1 || WR_HIGH_CYC > CNT_MAX) begin : g_bad_high
        $error("lcd_bus_writer: WR_HIGH_CYC must be within 1..15");
    end
`ifdef LCD_BYTE_MODE_EN
    if (DW != 2 * BYTE_W) begin : g_bad_dw
        $error("lcd_bus_writer: byte mode needs a 16-bit payload");
    end
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cs_q;
    logic             rs_q;
    logic             wr_q;
    logic             busy_q;
    logic [LW-1:0]    data_q;

    logic             head_id;
    logic [DW-1:0]    head_pay;
    logic [LW-1:0]    head_lcd;
    logic             cnt_done;
    logic             last_strobe;
    logic             pop;

    assign head_id  = bus.fifo_rdata[ID_BIT];
    assign head_pay = bus.fifo_rdata[DW-1:0];
    assign cnt_done = (cnt == '0);

`ifdef LCD_BYTE_MODE_EN
    logic              half_q;
    logic [BYTE_W-1:0] lo_q;

    assign head_lcd    = head_pay[DW-1 -: BYTE_W];
    assign last_strobe = (half_q == HALF_LO);
`else
    assign head_lcd    = head_pay;
    assign last_strobe = 1'b1;
`endif

    // Pop only at the very end of an entry's final strobe, or from IDLE.
    assign pop = !bus.fifo_rempty &&
                 ((state == ST_IDLE) ||
                  (state == ST_WR_HI && cnt_done && last_strobe));

    assign bus.fifo_rinc = pop;
    assign bus.LCD_CS    = cs_q;
    assign bus.LCD_RS    = rs_q;
    assign bus.LCD_WR    = wr_q;
    assign bus.LCD_RD    = 1'b1;
    assign bus.LCD_DATA  = data_q;
    assign bus.busy      = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            cs_q   <= 1'b1;
            rs_q   <= ID_INS;
            wr_q   <= 1'b1;
            busy_q <= 1'b0;
            data_q <= '0;
`ifdef LCD_BYTE_MODE_EN
            half_q <= HALF_HI;
            lo_q   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    cs_q <= 1'b1;
                    if (pop) begin
                        rs_q   <= head_id;
                        data_q <= head_lcd;
`ifdef LCD_BYTE_MODE_EN
                        lo_q   <= head_pay[BYTE_W-1:0];
                        half_q <= HALF_HI;
`endif
                        cs_q   <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    wr_q  <= 1'b0;
                    cnt   <= LOW_LOAD;
                    state <= ST_WR_LO;
                end
                ST_WR_LO: begin
                    if (cnt_done) begin
                        wr_q  <= 1'b1;
                        cnt   <= HIGH_LOAD;
                        state <= ST_WR_HI;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WR_HI: begin
                    if (!cnt_done) begin
                        cnt <= cnt - 1'b1;
`ifdef LCD_BYTE_MODE_EN
                    end else if (!last_strobe) begin
                        // Low byte reuses the address setup of the high byte.
                        data_q <= lo_q;
                        half_q <= HALF_LO;
                        wr_q   <= 1'b0;
                        cnt    <= LOW_LOAD;
                        state  <= ST_WR_LO;
`endif
                    end else if (pop) begin
                        rs_q   <= head_id;
                        data_q <= head_lcd;
`ifdef LCD_BYTE_MODE_EN
                        lo_q   <= head_pay[BYTE_W-1:0];
                        half_q <= HALF_HI;
`endif
                        state  <= ST_SETUP;
                    end else begin
                        cs_q   <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed bench for lcd_bus_writer: default-timing instance plus a
// WR_LOW_CYC=1 / WR_HIGH_CYC=3 instance, each fed from a queue FIFO model.
module tb_lcd_bus_writer;

`ifdef LCD_BYTE_MODE_EN
    localparam int LW = 8;
`else
    localparam int LW = 16;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lcd_bus_writer_if #(.DW(16)) bus_a ();
    lcd_bus_writer_if #(.DW(16)) bus_b ();

    lcd_bus_writer #(.DW(16), .WR_LOW_CYC(2), .WR_HIGH_CYC(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    lcd_bus_writer #(.DW(16), .WR_LOW_CYC(1), .WR_HIGH_CYC(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_pass  = 0;
    int n_total = 0;
    int pops_a  = 0;
    int pops_b  = 0;

    logic [16:0]   qa[$];
    logic [16:0]   qb[$];
    logic [31:0]   cs_v;
    logic [31:0]   wr_v;
    logic [31:0]   rs_v;
    logic [31:0]   busy_v;
    logic [LW-1:0] d_s[32];

    task automatic refresh;
        bus_a.fifo_rempty = (qa.size() == 0);
        bus_a.fifo_rdata  = (qa.size() != 0) ? qa[0] : '0;
        bus_b.fifo_rempty = (qb.size() == 0);
        bus_b.fifo_rdata  = (qb.size() != 0) ? qb[0] : '0;
    endtask

    // One clock: honour pops seen at the edge, then land on the next negedge.
    task automatic tick;
        logic ra, rb;
        @(posedge clk);
        ra = bus_a.fifo_rinc;
        rb = bus_b.fifo_rinc;
        #1;
        if (ra === 1'b1 && qa.size() != 0) begin
            void'(qa.pop_front());
            pops_a++;
        end
        if (rb === 1'b1 && qb.size() != 0) begin
            void'(qb.pop_front());
            pops_b++;
        end
        refresh();
        @(negedge clk);
    endtask

    task automatic capture_a(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            cs_v[i]   = bus_a.LCD_CS;
            wr_v[i]   = bus_a.LCD_WR;
            rs_v[i]   = bus_a.LCD_RS;
            busy_v[i] = bus_a.busy;
            d_s[i]    = bus_a.LCD_DATA;
        end
    endtask

    task automatic capture_b(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            cs_v[i]   = bus_b.LCD_CS;
            wr_v[i]   = bus_b.LCD_WR;
            rs_v[i]   = bus_b.LCD_RS;
            busy_v[i] = bus_b.busy;
            d_s[i]    = bus_b.LCD_DATA;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        refresh();
        tick();
        tick();
        n_total++;
        if ({bus_a.LCD_CS, bus_a.LCD_WR, bus_a.LCD_RS, bus_a.LCD_RD, bus_a.busy, bus_a.fifo_rinc} !== 6'b110100) begin
            $display("FAIL reset_ctrl: got cs/wr/rs/rd/busy/rinc=%b expected 110100",
                     {bus_a.LCD_CS, bus_a.LCD_WR, bus_a.LCD_RS, bus_a.LCD_RD, bus_a.busy, bus_a.fifo_rinc});
        end else n_pass++;
        n_total++;
        if (bus_a.LCD_DATA !== '0) begin
            $display("FAIL reset_data: got %h expected 0", bus_a.LCD_DATA);
        end else n_pass++;
        rst_n = 1'b1;
        tick();
        tick();
    endtask

`ifndef LCD_BYTE_MODE_EN
    task automatic test_single;
        int p0;
        p0 = pops_a;
        qa.push_back({1'b0, 16'h002A});
        refresh();
        capture_a(6);
        n_total++;
        if (pops_a - p0 !== 1) $display("FAIL single_pops: got %0d expected 1", pops_a - p0);
        else n_pass++;
        n_total++;
        if (cs_v[5:0] !== 6'b100000) $display("FAIL single_cs: got %b expected 100000", cs_v[5:0]);
        else n_pass++;
        n_total++;
        if (wr_v[5:0] !== 6'b111001) $display("FAIL single_wr: got %b expected 111001", wr_v[5:0]);
        else n_pass++;
        n_total++;
        if ({rs_v[3], d_s[3]} !== {1'b0, 16'h002A})
            $display("FAIL single_rise: got rs=%b data=%h expected rs=0 data=002a", rs_v[3], d_s[3]);
        else n_pass++;
        n_total++;
        if ({busy_v[0], busy_v[5]} !== 2'b10)
            $display("FAIL single_busy: got first/last=%b expected 10", {busy_v[0], busy_v[5]});
        else n_pass++;
    endtask

    task automatic test_burst;
        int p0;
        p0 = pops_a;
        qa.push_back({1'b1, 16'hF800});
        qa.push_back({1'b1, 16'h07E0});
        qa.push_back({1'b1, 16'h001F});
        refresh();
        capture_a(16);
        n_total++;
        if (pops_a - p0 !== 3) $display("FAIL burst_pops: got %0d expected 3", pops_a - p0);
        else n_pass++;
        n_total++;
        if (cs_v[15:0] !== 16'h8000) $display("FAIL burst_cs: got %h expected 8000", cs_v[15:0]);
        else n_pass++;
        n_total++;
        if (wr_v[15:0] !== 16'hE739) $display("FAIL burst_wr: got %h expected e739", wr_v[15:0]);
        else n_pass++;
        n_total++;
        if ({rs_v[3], rs_v[8], rs_v[13]} !== 3'b111)
            $display("FAIL burst_rs: got %b expected 111", {rs_v[3], rs_v[8], rs_v[13]});
        else n_pass++;
        n_total++;
        if ({d_s[3], d_s[8], d_s[13]} !== {16'hF800, 16'h07E0, 16'h001F})
            $display("FAIL burst_data: got %h %h %h expected f800 07e0 001f", d_s[3], d_s[8], d_s[13]);
        else n_pass++;
    endtask

    task automatic test_starvation;
        int  p0;
        bit  idle_ok;
        p0 = pops_a;
        qa.push_back({1'b1, 16'h1234});
        refresh();
        capture_a(6);
        n_total++;
        if (d_s[3] !== 16'h1234) $display("FAIL starve_first: got %h expected 1234", d_s[3]);
        else n_pass++;
        idle_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_a.LCD_CS !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.fifo_rinc !== 1'b0) idle_ok = 1'b0;
        end
        n_total++;
        if (!idle_ok) $display("FAIL starve_idle: got cs/busy not idle in gap expected cs=1 busy=0");
        else n_pass++;
        qa.push_back({1'b0, 16'h5678});
        refresh();
        capture_a(6);
        n_total++;
        if ({cs_v[5:0], wr_v[5:0]} !== {6'b100000, 6'b111001})
            $display("FAIL starve_second_shape: got cs=%b wr=%b expected cs=100000 wr=111001", cs_v[5:0], wr_v[5:0]);
        else n_pass++;
        n_total++;
        if ({rs_v[3], d_s[3]} !== {1'b0, 16'h5678})
            $display("FAIL starve_second_data: got rs=%b data=%h expected rs=0 data=5678", rs_v[3], d_s[3]);
        else n_pass++;
        n_total++;
        if (pops_a - p0 !== 2) $display("FAIL starve_pops: got %0d expected 2", pops_a - p0);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int p_mid;
        qa.push_back({1'b1, 16'hBEEF});
        refresh();
        tick();
        tick();
        n_total++;
        if (bus_a.LCD_WR !== 1'b0) $display("FAIL mid_in_wr_lo: got wr=%b expected 0", bus_a.LCD_WR);
        else n_pass++;
        p_mid = pops_a;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus_a.LCD_CS, bus_a.LCD_WR, bus_a.LCD_RS, bus_a.busy, bus_a.LCD_DATA} !== {4'b1100, 16'h0000})
            $display("FAIL mid_async_reset: got cs/wr/rs/busy=%b data=%h expected 1100 data=0000",
                     {bus_a.LCD_CS, bus_a.LCD_WR, bus_a.LCD_RS, bus_a.busy}, bus_a.LCD_DATA);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_total++;
        if (pops_a !== p_mid || bus_a.LCD_CS !== 1'b1)
            $display("FAIL mid_no_replay: got pops=%0d cs=%b expected pops=%0d cs=1", pops_a, bus_a.LCD_CS, p_mid);
        else n_pass++;
        qa.push_back({1'b0, 16'h00C3});
        refresh();
        capture_a(6);
        n_total++;
        if ({wr_v[5:0], rs_v[3], d_s[3]} !== {6'b111001, 1'b0, 16'h00C3})
            $display("FAIL mid_next_entry: got wr=%b rs=%b data=%h expected wr=111001 rs=0 data=00c3",
                     wr_v[5:0], rs_v[3], d_s[3]);
        else n_pass++;
        n_total++;
        if (pops_a - p_mid !== 1 || qa.size() != 0)
            $display("FAIL mid_pops: got %0d left=%0d expected 1 left=0", pops_a - p_mid, qa.size());
        else n_pass++;
    endtask

    task automatic test_timing_params;
        bit stable_ok;
        qb.push_back({1'b1, 16'hAAAA});
        qb.push_back({1'b1, 16'h5555});
        refresh();
        capture_b(11);
        n_total++;
        if (cs_v[10:0] !== 11'h400) $display("FAIL timing_cs: got %h expected 400", cs_v[10:0]);
        else n_pass++;
        n_total++;
        if (wr_v[10:0] !== 11'h7BD) $display("FAIL timing_wr: got %h expected 7bd", wr_v[10:0]);
        else n_pass++;
        stable_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (d_s[i] !== ((i < 5) ? 16'hAAAA : 16'h5555)) stable_ok = 1'b0;
        end
        n_total++;
        if (!stable_ok) $display("FAIL timing_data_stable: got d2=%h d7=%h expected aaaa 5555", d_s[2], d_s[7]);
        else n_pass++;
        n_total++;
        if (pops_b !== 2) $display("FAIL timing_pops: got %0d expected 2", pops_b);
        else n_pass++;
    endtask
`else
    task automatic test_byte_mode;
        int p0;
        p0 = pops_a;
        qa.push_back({1'b1, 16'hABCD});
        refresh();
        capture_a(10);
        n_total++;
        if (cs_v[9:0] !== 10'h200) $display("FAIL byte_cs: got %h expected 200", cs_v[9:0]);
        else n_pass++;
        n_total++;
        if (wr_v[9:0] !== 10'h399) $display("FAIL byte_wr: got %h expected 399", wr_v[9:0]);
        else n_pass++;
        n_total++;
        if ({d_s[3], d_s[7]} !== {8'hAB, 8'hCD})
            $display("FAIL byte_data: got %h %h expected ab cd", d_s[3], d_s[7]);
        else n_pass++;
        n_total++;
        if ({rs_v[3], rs_v[7]} !== 2'b11) $display("FAIL byte_rs: got %b expected 11", {rs_v[3], rs_v[7]});
        else n_pass++;
        n_total++;
        if (pops_a - p0 !== 1) $display("FAIL byte_pops: got %0d expected 1", pops_a - p0);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
`ifndef LCD_BYTE_MODE_EN
        test_single();
        test_burst();
        test_starvation();
        test_reset_mid();
        test_timing_params();
`else
        test_byte_mode();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
